// File: rtl/share_bus_codec_if.sv
// Bundle of handshake and data signals for share_bus_codec.
// The DUT side uses the slave modport; the producer/consumer side uses master.
interface share_bus_codec_if #(
    parameter int D     = 2,
    parameter int COUNT = 128
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 dir;
    logic                 swap;
    logic [COUNT*D-1:0]   data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [COUNT*D-1:0]   data_out;
    logic [COUNT-1:0]     rec_out;

    modport master (
        output in_valid, dir, swap, data_in, out_ready,
        input  in_ready, out_valid, data_out, rec_out
    );

    modport slave (
        input  in_valid, dir, swap, data_in, out_ready,
        output in_ready, out_valid, data_out, rec_out
    );
endinterface

// File: rtl/share_bus_codec.sv
// Converts D masked shares between per-share layout and bit-interleaved shbus layout,
// with optional per-share group reversal. Macro SHBUS_RECOMBINE_EN enables rec_out.
module share_bus_codec #(
    parameter int D     = 2,
    parameter int COUNT = 128,
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    share_bus_codec_if.slave bus
);
    localparam int N = COUNT * D;
    localparam int G = COUNT / WIDTH;

    logic [D-1:0][COUNT-1:0] w_in_sh;
    logic [D-1:0][COUNT-1:0] w_sw_sh;
    logic [N-1:0]            w_next;
    logic                    w_accept;

    logic                    r_valid;
    logic [N-1:0]            r_data;

    // dir=1 reads shbus layout (bit j of share i at j*D+i), dir=0 reads shares layout.
    always_comb begin
        w_in_sh = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < COUNT; j++) begin
                if (bus.dir) w_in_sh[i][j] = bus.data_in[j*D+i];
                else         w_in_sh[i][j] = bus.data_in[i*COUNT+j];
            end
        end
    end

    always_comb begin
        w_sw_sh = w_in_sh;
        if (bus.swap) begin
            for (int i = 0; i < D; i++) begin
                for (int k = 0; k < G; k++) begin
                    w_sw_sh[i][(G-1-k)*WIDTH +: WIDTH] = w_in_sh[i][k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_next = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < COUNT; j++) begin
                if (bus.dir) w_next[i*COUNT+j] = w_sw_sh[i][j];
                else         w_next[j*D+i]     = w_sw_sh[i][j];
            end
        end
    end

    // Handshake: a word moves when valid and ready are both high at a rising edge;
    // the output register may refill in the same cycle it is drained.
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_next;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.data_out  = r_data;

`ifdef SHBUS_RECOMBINE_EN
    logic [COUNT-1:0] w_rec;
    logic [COUNT-1:0] r_rec;

    always_comb begin
        w_rec = '0;
        for (int i = 0; i < D; i++) begin
            w_rec = w_rec ^ w_sw_sh[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_rec <= '0;
        else if (w_accept) r_rec <= w_rec;
    end

    assign bus.rec_out = r_rec;
`else
    assign bus.rec_out = '0;
`endif
endmodule

// File: tb/tb_share_bus_codec.sv
// Directed bench for share_bus_codec: three instances covering D=2/COUNT=8,
// D=2/COUNT=128 and D=3/COUNT=128 with hand-computed expectations.
module tb_share_bus_codec;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    share_bus_codec_if #(.D(2), .COUNT(8))   if0 ();
    share_bus_codec_if #(.D(2), .COUNT(128)) if1 ();
    share_bus_codec_if #(.D(3), .COUNT(128)) if2 ();

    share_bus_codec #(.D(2), .COUNT(8),   .WIDTH(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    share_bus_codec #(.D(2), .COUNT(128), .WIDTH(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    share_bus_codec #(.D(3), .COUNT(128), .WIDTH(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rec_exp(input logic [127:0] v);
`ifdef SHBUS_RECOMBINE_EN
        return v;
`else
        return '0;
`endif
    endfunction

    // Reference interleaver: bit j of share i lands at j*d+i.
    function automatic logic [383:0] interleave(input logic [383:0] sh, input int d, input int count);
        logic [383:0] r;
        r = '0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < count; j++)
                r[j*d+i] = sh[i*count+j];
        return r;
    endfunction

    logic [127:0] a, b, c;
    logic [383:0] shbus3;
    logic [255:0] shbus2;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        {if0.in_valid, if0.dir, if0.swap, if0.out_ready} = '0; if0.data_in = '0;
        {if1.in_valid, if1.dir, if1.swap, if1.out_ready} = '0; if1.data_in = '0;
        {if2.in_valid, if2.dir, if2.swap, if2.out_ready} = '0; if2.data_in = '0;
        #2;
        check("rst_out_valid0", if0.out_valid, 0);
        check("rst_data_out0",  if0.data_out,  0);
        check("rst_rec_out0",   if0.rec_out,   0);
        check("rst_in_ready0",  if0.in_ready,  1);
        check("rst_out_valid2", if2.out_valid, 0);
        #10;
        rst = 1'b1;
        tick();

        // Basic shares->shbus on D=2/COUNT=8.
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.data_in   = 16'h000F;
        tick();
        check("v030_valid", if0.out_valid, 1);
        check("v030_data",  if0.data_out,  16'h0055);
        check("v030_rec",   if0.rec_out,   rec_exp(128'h0F));

        if0.data_in = 16'hF000;
        tick();
        check("v031a_data", if0.data_out, 16'hAA00);
        check("v031a_rec",  if0.rec_out,  rec_exp(128'hF0));

        if0.dir     = 1'b1;
        if0.data_in = 16'hAA00;
        tick();
        check("v031b_data", if0.data_out, 16'hF000);
        check("v031b_rec",  if0.rec_out,  rec_exp(128'hF0));

        if0.in_valid = 1'b0;
        if0.dir      = 1'b0;
        tick();
        check("drain_valid", if0.out_valid, 0);

        // Group reversal on COUNT=128, then swap back through dir=1.
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.swap      = 1'b1;
        if1.data_in   = {128'h0, 128'hffeeddccbbaa99887766554433221100};
        tick();
        shbus2 = interleave({256'h0, 128'h0, 128'h00112233445566778899aabbccddeeff}, 2, 128);
        check("v032_rec",  if1.rec_out,  rec_exp(128'h00112233445566778899aabbccddeeff));
        check("v032_data", if1.data_out, shbus2);
        if1.dir     = 1'b1;
        if1.data_in = shbus2;
        tick();
        check("v032_back_data", if1.data_out, {128'h0, 128'hffeeddccbbaa99887766554433221100});
        check("v032_back_rec",  if1.rec_out,  rec_exp(128'hffeeddccbbaa99887766554433221100));
        if1.in_valid = 1'b0;
        tick();
        check("v032_drain", if1.out_valid, 0);

        // D=3 round trip with random shares.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        if2.out_ready = 1'b1;
        if2.in_valid  = 1'b1;
        if2.data_in   = {c, b, a};
        tick();
        shbus3 = interleave({c, b, a}, 3, 128);
        check("v033_fwd_data", if2.data_out, shbus3);
        check("v033_fwd_rec",  if2.rec_out,  rec_exp(a ^ b ^ c));
        if2.dir     = 1'b1;
        if2.data_in = shbus3;
        tick();
        check("v033_back_data", if2.data_out, {c, b, a});
        check("v033_back_rec",  if2.rec_out,  rec_exp(a ^ b ^ c));
        if2.in_valid = 1'b0;
        tick();

        // Back-pressure: word held for 5 cycles, then drained and refilled together.
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.data_in   = 16'h000F;
        tick();
        if0.data_in = 16'hF000;
        for (int n = 0; n < 5; n++) begin
            check("bp_valid",    if0.out_valid, 1);
            check("bp_data",     if0.data_out,  16'h0055);
            check("bp_in_ready", if0.in_ready,  0);
            tick();
        end
        if0.out_ready = 1'b1;
        #1;
        check("bp_release_ready", if0.in_ready, 1);
        tick();
        check("bp_next_valid", if0.out_valid, 1);
        check("bp_next_data",  if0.data_out,  16'hAA00);
        if0.in_valid = 1'b0;
        tick();
        check("bp_end_valid", if0.out_valid, 0);

        // Asynchronous reset between edges while a word is held.
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.data_in   = 16'h000F;
        tick();
        if0.in_valid = 1'b0;
        check("ar_pre_valid", if0.out_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_valid",    if0.out_valid, 0);
        check("ar_data",     if0.data_out,  0);
        check("ar_rec",      if0.rec_out,   0);
        check("ar_in_ready", if0.in_ready,  1);
        @(negedge clk);
        rst = 1'b1;
        if0.out_ready = 1'b1;
        tick();
        check("ar_no_stale", if0.out_valid, 0);
        tick();
        check("ar_no_stale2", if0.out_valid, 0);
        if0.in_valid = 1'b1;
        if0.data_in  = 16'hF000;
        tick();
        check("ar_new_valid", if0.out_valid, 1);
        check("ar_new_data",  if0.data_out,  16'hAA00);
        if0.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/share_bus_codec.md
SHARE_BUS_CODEC -- requirements
Module: share_bus_codec

Interface
- REQ-001 SHALL have parameter D, default 2, meaning the number of shares (D >= 2).
- REQ-002 SHALL have parameter COUNT, default 128, meaning the bits per share (a multiple of WIDTH).
- REQ-003 SHALL have parameter WIDTH, default 8, meaning the group size for endian reversal (bytes by default).
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
- REQ-006 SHALL have port in_valid, input, 1 bit: input word offered.
- REQ-007 SHALL have port in_ready, output, 1 bit: input word accepted when in_valid=1 and in_ready=1.
- REQ-008 SHALL have port dir, input, 1 bit: 0 = shares->shbus, 1 = shbus->shares; sampled with the input word.
- REQ-009 SHALL have port swap, input, 1 bit: 1 = endian-reverse each share; sampled with the input word.
- REQ-010 SHALL have port data_in, input, COUNT*D bits: input word.
- REQ-011 SHALL have port out_valid, output, 1 bit: output word held.
- REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid=1 and out_ready=1.
- REQ-013 SHALL have port data_out, output, COUNT*D bits: converted word.
- REQ-014 SHALL have port rec_out, output, COUNT bits: unmasked value, the XOR of all shares.

Function
- REQ-015 SHALL use two layouts: shares layout = share i at bits [i*COUNT +: COUNT]; shbus layout = bit j of share i at bit index j*D+i.
- REQ-016 SHALL, for dir=0, treat data_in as shares layout, apply the optional swap to each share, and emit the result in shbus layout.
- REQ-017 SHALL, for dir=1, treat data_in as shbus layout, extract the shares, apply the optional swap to each share, and emit the result in shares layout.
- REQ-018 SHALL implement swap so that WIDTH-bit group k of a share moves to group COUNT/WIDTH-1-k, with bit order inside each group kept; swap=0 passes shares unchanged.
- REQ-019 SHALL set rec_out to the XOR over i of share i after the swap stage, registered together with data_out.
- REQ-020 SHALL implement one register stage with latency 1 cycle: an accepted word appears on data_out/rec_out at the next rising edge with out_valid=1.
- REQ-021 SHALL drive in_ready = !out_valid | out_ready, combinationally, giving full throughput of 1 word/cycle.
- REQ-022 SHALL hold data_out, rec_out and out_valid stable while out_valid=1 and out_ready=0 (back-pressure).
- REQ-023 SHALL clear out_valid on the output handshake when no input is accepted in the same cycle.
- REQ-024 SHALL, when output handshake and input acceptance occur in the same cycle, load the new word and keep out_valid=1.
- REQ-025 SHALL contain no combinational path from data_in to data_out.

Reset
- REQ-026 SHALL, while rst=0 (asynchronous), force out_valid=0, data_out=0 and rec_out=0; in_ready=1 follows from REQ-021.
- REQ-027 SHALL discard any held word when reset is asserted mid-operation; no output handshake occurs until a new word is accepted after release.

Configuration
- REQ-028 SHALL, with macro SHBUS_RECOMBINE_EN defined, compute and register rec_out per REQ-019.
- REQ-029 SHALL, without SHBUS_RECOMBINE_EN, keep the rec_out port but tie it constantly to 0 and instantiate no recombination XOR or register logic.

Verification
- REQ-030 SHALL cover: D=2, COUNT=8, dir=0, swap=0, data_in share0=0x0F, share1=0x00 -> data_out=0x0055 and rec_out=0x0F.
- REQ-031 SHALL cover: D=2, COUNT=8, dir=0, share0=0x00, share1=0xF0 -> data_out=0xAA00; then dir=1 with data_in=0xAA00 -> data_out=0xF000 (shares layout) and rec_out=0xF0.
- REQ-032 SHALL cover: D=2, COUNT=128, dir=0, swap=1, share0=0xffeeddccbbaa99887766554433221100, share1=0 -> rec_out=0x00112233445566778899aabbccddeeff.
- REQ-033 SHALL cover: D=3, COUNT=128, random shares a, b, c -> rec_out=a^b^c, and round-trip dir=0 then dir=1 (swap=0) returns a, b, c.
- REQ-034 SHALL cover: out_ready held 0 for 5 cycles with in_valid=1 -> one word held stable, in_ready=0; on release, one handshake and the next word follows 1 cycle later.
- REQ-035 SHALL cover: rst pulled low between clock edges while out_valid=1 -> out_valid=0 immediately, outputs 0, and no stale word after release.
